// File: rtl/vector_multiplier.sv
// Single-cycle parallel unsigned vector multiplier: element-wise products plus dot product, registered on trigger.
// Optional build macro VECTOR_MULTIPLIER_SAT_EN switches from wrap-around to saturating results and adds `overflow`.
module vector_multiplier #(
  parameter int ELEMENT_SIZE = 16,
  parameter int VECTOR_SIZE  = 20
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                trigger,
  input  logic [ELEMENT_SIZE*VECTOR_SIZE-1:0] vector_a,
  input  logic [ELEMENT_SIZE*VECTOR_SIZE-1:0] vector_b,
  output logic [ELEMENT_SIZE*VECTOR_SIZE-1:0] result,
  output logic [ELEMENT_SIZE-1:0]             dot_product,
  output logic                                done,
`ifdef VECTOR_MULTIPLIER_SAT_EN
  output logic                                overflow,
`endif
  output logic                                dbg_state_o,
  output logic [2*ELEMENT_SIZE+$clog2(VECTOR_SIZE)-1:0] dbg_sum_o
);

  localparam int VEC_W       = ELEMENT_SIZE * VECTOR_SIZE;
  localparam int PROD_W      = 2 * ELEMENT_SIZE;
  localparam int ACC_W       = PROD_W + $clog2(VECTOR_SIZE);
  localparam int TREE_LVL    = $clog2(VECTOR_SIZE);
  localparam int TREE_LEAVES = 1 << TREE_LVL;

  // Handshake: trigger is sampled on every rising edge with no back-pressure;
  // done is high for exactly the cycle after each accepted trigger.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   result_q, result_d;
  logic [ELEMENT_SIZE-1:0] dot_q, dot_d;
  logic [ACC_W-1:0]   sum_q, sum_d;

  logic [VEC_W-1:0]   comp_result;
  logic [ELEMENT_SIZE-1:0] comp_dot;
  logic [ACC_W-1:0]   comp_sum;

`ifdef VECTOR_MULTIPLIER_SAT_EN
  logic               ovf_q, ovf_d;
  logic               comp_sat;
`endif

  // Multipliers and a balanced adder tree; the tree is sized so the sum is exact.
  always_comb begin : datapath
    logic [PROD_W-1:0] prod [VECTOR_SIZE];
    logic [ACC_W-1:0]  node [TREE_LVL+1][TREE_LEAVES];
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      prod[i] = PROD_W'(vector_a[i*ELEMENT_SIZE +: ELEMENT_SIZE])
              * PROD_W'(vector_b[i*ELEMENT_SIZE +: ELEMENT_SIZE]);
    end
    for (int l = 0; l <= TREE_LVL; l++) begin
      for (int j = 0; j < TREE_LEAVES; j++) begin
        node[l][j] = '0;
      end
    end
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      node[0][i] = ACC_W'(prod[i]);
    end
    for (int l = 0; l < TREE_LVL; l++) begin
      for (int j = 0; j < (TREE_LEAVES >> (l + 1)); j++) begin
        node[l+1][j] = node[l][2*j] + node[l][2*j+1];
      end
    end
    comp_sum    = node[TREE_LVL][0];
    comp_result = '0;
    comp_dot    = '0;
`ifdef VECTOR_MULTIPLIER_SAT_EN
    comp_sat = 1'b0;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      if (|prod[i][PROD_W-1:ELEMENT_SIZE]) begin
        comp_result[i*ELEMENT_SIZE +: ELEMENT_SIZE] = '1;
        comp_sat = 1'b1;
      end else begin
        comp_result[i*ELEMENT_SIZE +: ELEMENT_SIZE] = prod[i][ELEMENT_SIZE-1:0];
      end
    end
    if (|comp_sum[ACC_W-1:ELEMENT_SIZE]) begin
      comp_dot = '1;
      comp_sat = 1'b1;
    end else begin
      comp_dot = comp_sum[ELEMENT_SIZE-1:0];
    end
`else
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      comp_result[i*ELEMENT_SIZE +: ELEMENT_SIZE] = prod[i][ELEMENT_SIZE-1:0];
    end
    comp_dot = comp_sum[ELEMENT_SIZE-1:0];
`endif
  end

  // Next state: an accepted trigger loads fresh results, otherwise everything holds.
  always_comb begin
    state_d  = ST_IDLE;
    result_d = result_q;
    dot_d    = dot_q;
    sum_d    = sum_q;
`ifdef VECTOR_MULTIPLIER_SAT_EN
    ovf_d    = ovf_q;
`endif
    if (trigger) begin
      state_d  = ST_DONE;
      result_d = comp_result;
      dot_d    = comp_dot;
      sum_d    = comp_sum;
`ifdef VECTOR_MULTIPLIER_SAT_EN
      ovf_d    = comp_sat;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      dot_q    <= '0;
      sum_q    <= '0;
`ifdef VECTOR_MULTIPLIER_SAT_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      dot_q    <= dot_d;
      sum_q    <= sum_d;
`ifdef VECTOR_MULTIPLIER_SAT_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign result      = result_q;
  assign dot_product = dot_q;
  assign done        = (state_q == ST_DONE);
  assign dbg_state_o = logic'(state_q);
  assign dbg_sum_o   = sum_q;
`ifdef VECTOR_MULTIPLIER_SAT_EN
  assign overflow    = ovf_q;
`endif

endmodule

// File: tb/tb_vector_multiplier.sv
// Self-checking bench for vector_multiplier: directed cases plus randomized triggers against an arithmetic model.
// Build with +define+VECTOR_MULTIPLIER_SAT_EN to exercise the saturating variant.
module tb_vector_multiplier;

  localparam int ES = 16;
  localparam int VS = 20;
  localparam int VW = ES * VS;
  localparam int AW = 2 * ES + $clog2(VS);
  localparam longint unsigned MAXV = (64'd1 << ES) - 64'd1;

  logic          clk = 1'b0;
  logic          rst;
  logic          trigger;
  logic [VW-1:0] vector_a;
  logic [VW-1:0] vector_b;
  logic [VW-1:0] result;
  logic [ES-1:0] dot_product;
  logic          done;
  logic          dbg_state_o;
  logic [AW-1:0] dbg_sum_o;
`ifdef VECTOR_MULTIPLIER_SAT_EN
  logic          overflow;
`endif

  vector_multiplier #(.ELEMENT_SIZE(ES), .VECTOR_SIZE(VS)) dut (
    .clk         (clk),
    .rst         (rst),
    .trigger     (trigger),
    .vector_a    (vector_a),
    .vector_b    (vector_b),
    .result      (result),
    .dot_product (dot_product),
    .done        (done),
`ifdef VECTOR_MULTIPLIER_SAT_EN
    .overflow    (overflow),
`endif
    .dbg_state_o (dbg_state_o),
    .dbg_sum_o   (dbg_sum_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned   cur_a [VS];
  int unsigned   cur_b [VS];
  logic [VW-1:0] exp_vec;
  logic [ES-1:0] exp_dot;
  logic [AW-1:0] exp_sum;
  logic [VW-1:0] exp_q     [$];
  logic [ES-1:0] exp_dot_q [$];
  logic [AW-1:0] exp_sum_q [$];
`ifdef VECTOR_MULTIPLIER_SAT_EN
  logic          exp_ovf;
  logic          exp_ovf_q [$];
`endif

  // reference model: plain integer arithmetic on the current operand arrays
  function automatic void model();
    longint unsigned p;
    longint unsigned total;
    total = 0;
`ifdef VECTOR_MULTIPLIER_SAT_EN
    exp_ovf = 1'b0;
`endif
    for (int i = 0; i < VS; i++) begin
      p = 64'(cur_a[i]) * 64'(cur_b[i]);
      total += p;
`ifdef VECTOR_MULTIPLIER_SAT_EN
      if (p > MAXV) begin
        p = MAXV;
        exp_ovf = 1'b1;
      end
`else
      p = p % (MAXV + 1);
`endif
      exp_vec[i*ES +: ES] = ES'(p);
    end
    exp_sum = AW'(total);
`ifdef VECTOR_MULTIPLIER_SAT_EN
    if (total > MAXV) begin
      exp_dot = ES'(MAXV);
      exp_ovf = 1'b1;
    end else begin
      exp_dot = ES'(total);
    end
`else
    exp_dot = ES'(total % (MAXV + 1));
`endif
  endfunction

  // driver tasks
  task automatic rand_inputs(input int unsigned lo, input int unsigned hi);
    for (int i = 0; i < VS; i++) begin
      cur_a[i] = $urandom_range(hi, lo);
      cur_b[i] = $urandom_range(hi, lo);
    end
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < VS; i++) begin
      vector_a[i*ES +: ES] = ES'(cur_a[i]);
      vector_b[i*ES +: ES] = ES'(cur_b[i]);
    end
  endtask

  task automatic drive(input logic trg);
    @(negedge clk);
    trigger = trg;
    pack_inputs();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    trigger = 1'b1;
    rand_inputs(0, 65535);
    pack_inputs();
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
      n_checks++;
      if (dot_product !== '0) begin n_fail++; $display("FAIL reset_dot: got %0d expected 0", dot_product); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
`ifdef VECTOR_MULTIPLIER_SAT_EN
      n_checks++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
`endif
      rand_inputs(0, 65535);
      pack_inputs();
    end
    @(negedge clk);
    rst = 1'b0;
    trigger = 1'b0;
  endtask

  task automatic test_basic();
    logic [VW-1:0] want;
    for (int i = 0; i < VS; i++) begin
      cur_a[i] = 2;
      cur_b[i] = 3;
      want[i*ES +: ES] = 16'd6;
    end
    drive(1'b1);
    tick();
    n_checks++;
    if (result !== want) begin n_fail++; $display("FAIL basic_result: got %h expected %h", result, want); end
    n_checks++;
    if (dot_product !== 16'd120) begin n_fail++; $display("FAIL basic_dot: got %0d expected 120", dot_product); end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", done); end
    drive(1'b0);
    tick();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
    n_checks++;
    if (result !== want || dot_product !== 16'd120) begin
      n_fail++;
      $display("FAIL basic_hold: got dot %0d expected 120", dot_product);
    end
  endtask

  task automatic test_ramp();
    logic [VW-1:0] want;
    for (int i = 0; i < VS; i++) begin
      cur_a[i] = i + 1;
      cur_b[i] = 64;
      want[i*ES +: ES] = ES'(64 * (i + 1));
    end
    drive(1'b1);
    tick();
    n_checks++;
    if (result !== want) begin n_fail++; $display("FAIL ramp_result: got %h expected %h", result, want); end
    n_checks++;
    if (dot_product !== 16'd13440) begin n_fail++; $display("FAIL ramp_dot: got %0d expected 13440", dot_product); end
    n_checks++;
    if (dbg_sum_o !== AW'(13440)) begin n_fail++; $display("FAIL ramp_sum: got %0d expected 13440", dbg_sum_o); end
  endtask

  task automatic test_wrap();
    logic [ES-1:0] want_dot;
    logic [ES-1:0] want_slot0;
`ifdef VECTOR_MULTIPLIER_SAT_EN
    want_dot   = 16'd65535;
    want_slot0 = 16'd65535;
`else
    want_dot   = 16'd16384;
    want_slot0 = 16'd24464;
`endif
    for (int i = 0; i < VS; i++) begin
      cur_a[i] = 64;
      cur_b[i] = 64;
    end
    drive(1'b1);
    tick();
    n_checks++;
    if (result[ES-1:0] !== 16'd4096 || result[VW-1 -: ES] !== 16'd4096) begin
      n_fail++;
      $display("FAIL wrap_slots: got %h expected all 1000", result);
    end
    n_checks++;
    if (dot_product !== want_dot) begin n_fail++; $display("FAIL wrap_dot: got %0d expected %0d", dot_product, want_dot); end
    n_checks++;
    if (dbg_sum_o !== AW'(81920)) begin n_fail++; $display("FAIL wrap_sum: got %0d expected 81920", dbg_sum_o); end
`ifdef VECTOR_MULTIPLIER_SAT_EN
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL wrap_overflow: got %b expected 1", overflow); end
`endif
    for (int i = 0; i < VS; i++) begin
      cur_a[i] = 1;
      cur_b[i] = 1;
    end
    cur_a[0] = 300;
    cur_b[0] = 300;
    model();
    drive(1'b1);
    tick();
    n_checks++;
    if (result[ES-1:0] !== want_slot0) begin n_fail++; $display("FAIL wrap_elem300: got %0d expected %0d", result[ES-1:0], want_slot0); end
    n_checks++;
    if (result !== exp_vec || dot_product !== exp_dot) begin
      n_fail++;
      $display("FAIL wrap_elem300_model: got dot %0d expected %0d", dot_product, exp_dot);
    end
`ifdef VECTOR_MULTIPLIER_SAT_EN
    for (int i = 0; i < VS; i++) begin
      cur_a[i] = 1;
      cur_b[i] = 1;
    end
    drive(1'b1);
    tick();
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_overflow_clear: got %b expected 0", overflow); end
`endif
  endtask

  task automatic test_hold();
    rand_inputs(1, 64);
    model();
    drive(1'b1);
    tick();
    n_checks++;
    if (result !== exp_vec || dot_product !== exp_dot) begin
      n_fail++;
      $display("FAIL hold_load: got dot %0d expected %0d", dot_product, exp_dot);
    end
    for (int c = 0; c < 5; c++) begin
      rand_inputs(0, 65535);
      drive(1'b0);
      tick();
      n_checks++;
      if (result !== exp_vec) begin n_fail++; $display("FAIL hold_result: got %h expected %h", result, exp_vec); end
      n_checks++;
      if (dot_product !== exp_dot) begin n_fail++; $display("FAIL hold_dot: got %0d expected %0d", dot_product, exp_dot); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL hold_done: got %b expected 0", done); end
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] w_vec;
    logic [ES-1:0] w_dot;
    logic [AW-1:0] w_sum;
    for (int n = 0; n < 1000; n++) begin
      rand_inputs(1, 64);
      model();
      exp_q.push_back(exp_vec);
      exp_dot_q.push_back(exp_dot);
      exp_sum_q.push_back(exp_sum);
`ifdef VECTOR_MULTIPLIER_SAT_EN
      exp_ovf_q.push_back(exp_ovf);
`endif
      drive(1'b1);
      tick();
      w_vec = exp_q.pop_front();
      w_dot = exp_dot_q.pop_front();
      w_sum = exp_sum_q.pop_front();
      n_checks++;
      if (result !== w_vec) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h expected %h", n, result, w_vec); end
      n_checks++;
      if (dot_product !== w_dot) begin n_fail++; $display("FAIL b2b_dot[%0d]: got %0d expected %0d", n, dot_product, w_dot); end
      n_checks++;
      if (dbg_sum_o !== w_sum) begin n_fail++; $display("FAIL b2b_sum[%0d]: got %0d expected %0d", n, dbg_sum_o, w_sum); end
      n_checks++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done[%0d]: got %b expected 1", n, done); end
`ifdef VECTOR_MULTIPLIER_SAT_EN
      n_checks++;
      if (overflow !== exp_ovf_q.pop_front()) begin n_fail++; $display("FAIL b2b_overflow[%0d]: got %b", n, overflow); end
`endif
      if ($urandom_range(1, 0) == 1) begin
        drive(1'b0);
        tick();
        n_checks++;
        if (done !== 1'b0 || dot_product !== w_dot) begin
          n_fail++;
          $display("FAIL b2b_gap[%0d]: got done %b dot %0d expected 0 %0d", n, done, dot_product, w_dot);
        end
      end
    end
  endtask

  task automatic test_priority();
    rand_inputs(1, 64);
    drive(1'b1);
    tick();
    rand_inputs(1, 64);
    drive(1'b1);
    rst = 1'b1;
    tick();
    n_checks++;
    if (result !== '0 || dot_product !== '0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL priority_reset: got dot %0d done %b expected 0 0", dot_product, done);
    end
    @(negedge clk);
    rst = 1'b0;
    trigger = 1'b0;
  endtask

  task automatic test_trigger_held();
    for (int c = 0; c < 3; c++) begin
      rand_inputs(0, 65535);
      model();
      drive(1'b1);
      tick();
      n_checks++;
      if (result !== exp_vec) begin n_fail++; $display("FAIL held_result[%0d]: got %h expected %h", c, result, exp_vec); end
      n_checks++;
      if (dot_product !== exp_dot) begin n_fail++; $display("FAIL held_dot[%0d]: got %0d expected %0d", c, dot_product, exp_dot); end
      n_checks++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL held_done[%0d]: got %b expected 1", c, done); end
`ifdef VECTOR_MULTIPLIER_SAT_EN
      n_checks++;
      if (overflow !== exp_ovf) begin n_fail++; $display("FAIL held_overflow[%0d]: got %b expected %b", c, overflow, exp_ovf); end
`endif
    end
    rand_inputs(0, 65535);
    drive(1'b0);
    tick();
    n_checks++;
    if (done !== 1'b0 || result !== exp_vec || dot_product !== exp_dot) begin
      n_fail++;
      $display("FAIL held_release: got done %b dot %0d expected 0 %0d", done, dot_product, exp_dot);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_ramp();
    test_wrap();
    test_hold();
    test_back_to_back();
    test_priority();
    test_trigger_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
